inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//   Runtime writer for the MIPS instruction memory; replaces file preload for hardware bring-up.
//   Accepts a byte stream (valid/ready) carrying a 16-bit word count plus big-endian 32-bit
//   instructions, and writes them to consecutive word addresses starting at 0.
//   Holds the CPU via cpu_hold while loading. Sits between the host byte source and the
//   instruction memory write port, alongside the MIPS top.
// PARAMETERS
//   ADDR_WIDTH  8   word-address bits of instruction memory; DEPTH = 2**ADDR_WIDTH words
// PORTS
//   clk_CPU       in   1             system clock, rising edge
//   rst           in   1             asynchronous, active-high reset
//   start         in   1             begin load session; sampled only in IDLE
//   byte_valid    in   1             byte_data valid
//   byte_data     in   8             stream byte
//   byte_ready    out  1             loader can accept a byte this cycle
//   mem_we        out  1             instruction memory write enable, 1-cycle pulse
//   mem_addr      out  ADDR_WIDTH    word address for the write
//   mem_wdata     out  32            instruction word
//   cpu_hold      out  1             high while a session is active; CPU kept in reset
//   busy          out  1             state != IDLE
//   done          out  1             1-cycle pulse on successful completion
//   error         out  1             sticky; header count > DEPTH
//   words_loaded  out  ADDR_WIDTH+1  words written in current/last session
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, counters 0. Reset mid-session abandons the load.
//     Memory words already written stay written.
//   Transfer: a byte is accepted when byte_valid && byte_ready.
//     byte_ready = 1 only in HDR_HI, HDR_LO, DATA.
//   FSM:
//     IDLE   : start=1 -> HDR_HI; error<=0, words_loaded<=0, cpu_hold<=1.
//     HDR_HI : accepted byte -> count[15:8]; go HDR_LO.
//     HDR_LO : accepted byte -> count[7:0]. Next state from the full count:
//              count==0 -> DONE; count>DEPTH -> ERR; else -> DATA, byte_idx=0, word_idx=0.
//     DATA   : accepted byte shifts into the assembly register, big-endian
//              (1st byte -> [31:24] ... 4th -> [7:0]); byte_idx wraps 3->0.
//              On the 4th byte: next cycle mem_we=1, mem_wdata=word, mem_addr=word_idx;
//              word_idx and words_loaded increment in that same cycle.
//              After word count: go DONE in the cycle mem_we pulses.
//              byte_ready remains 1 during the write pulse, so full rate is 1 byte/cycle.
//     DONE   : done=1, cpu_hold=1 for this cycle; next IDLE with cpu_hold=0.
//     ERR    : error<=1, no writes; next IDLE, cpu_hold<=0.
//   start outside IDLE is ignored. byte_valid in IDLE/DONE/ERR is not accepted.
//   Gaps in byte_valid stall progress indefinitely; no timeout.
//   count==DEPTH is legal: last address is DEPTH-1, words_loaded=DEPTH (needs ADDR_WIDTH+1 bits).
//   mem_addr and mem_wdata hold their last values when mem_we=0.
// TESTING
//   1. start; bytes 00 02 20 08 00 05 AC 01 00 04 back-to-back
//      -> mem_we@addr0=0x20080005, then @addr1=0xAC010004;
//      done pulse same cycle as 2nd write+1; words_loaded=2.
//   2. Header 00 00 -> no mem_we; done pulses 1 cycle after HDR_LO byte; cpu_hold drops next.
//   3. ADDR_WIDTH=8, header 01 01 (257) -> error=1, no writes, cpu_hold=0, returns IDLE;
//      next start clears error.
//   4. Random byte_valid gaps (~50%) with 3 words -> same memory contents as back-to-back;
//      no byte is lost or duplicated.
//   5. rst asserted after 6 data bytes -> all outputs 0 immediately; the one completed word
//      stays written; a new session loads normally.
//   6. start pulsed during DATA -> ignored; session completes unchanged; header 01 00 (256)
//      -> last write addr 0xFF, words_loaded=256.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Byte-stream loader for the MIPS instruction memory: 16-bit word count header followed by
// big-endian 32-bit words, written to consecutive addresses from 0 while the CPU is held.
module inst_mem_loader #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk_CPU,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {
      StIdle,
      StHdrHi,
      StHdrLo,
      StData,
      StDone,
      StErr
   } state_e;

   state_e                state_q, state_d;
   logic [7:0]            count_hi_q, count_hi_d;
   logic [15:0]           count_q, count_d;
   logic [23:0]           asm_q, asm_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  error_q, error_d;
   logic [ADDR_WIDTH:0]   words_q, words_d;

   logic [15:0] hdr_count;
   logic        all_written;
   logic        accept;

   assign hdr_count = {count_hi_q, byte_data};
   // True from the cycle the final write pulses; blocks a stray byte and ends the session.
   assign all_written = (32'(words_q) == 32'(count_q));

   always_comb begin
      byte_ready = 1'b0;
      unique case (state_q)
         StHdrHi, StHdrLo: byte_ready = 1'b1;
         StData:           byte_ready = !all_written;
         default:          byte_ready = 1'b0;
      endcase
   end

   assign accept = byte_valid && byte_ready;

   always_comb begin
      state_d     = state_q;
      count_hi_d  = count_hi_q;
      count_d     = count_q;
      asm_d       = asm_q;
      byte_idx_d  = byte_idx_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_hold_d  = cpu_hold_q;
      error_d     = error_q;
      words_d     = words_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StHdrHi;
               error_d    = 1'b0;
               words_d    = '0;
               cpu_hold_d = 1'b1;
            end
         end
         StHdrHi: begin
            if (accept) begin
               count_hi_d = byte_data;
               state_d    = StHdrLo;
            end
         end
         StHdrLo: begin
            if (accept) begin
               count_d = hdr_count;
               if (hdr_count == 16'd0) begin
                  state_d = StDone;
               end else if (32'(hdr_count) > Depth) begin
                  state_d = StErr;
               end else begin
                  state_d    = StData;
                  byte_idx_d = 2'd0;
               end
            end
         end
         StData: begin
            if (all_written) begin
               state_d = StDone;
            end else if (accept) begin
               asm_d      = {asm_q[15:0], byte_data};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = {asm_q, byte_data};
                  mem_addr_d  = words_q[ADDR_WIDTH-1:0];
                  words_d     = words_q + (ADDR_WIDTH + 1)'(1);
               end
            end
         end
         StDone: begin
            state_d    = StIdle;
            cpu_hold_d = 1'b0;
         end
         StErr: begin
            state_d    = StIdle;
            error_d    = 1'b1;
            cpu_hold_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_CPU or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         count_hi_q  <= '0;
         count_q     <= '0;
         asm_q       <= '0;
         byte_idx_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_hold_q  <= 1'b0;
         error_q     <= 1'b0;
         words_q     <= '0;
      end else begin
         state_q     <= state_d;
         count_hi_q  <= count_hi_d;
         count_q     <= count_d;
         asm_q       <= asm_d;
         byte_idx_q  <= byte_idx_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_hold_q  <= cpu_hold_d;
         error_q     <= error_d;
         words_q     <= words_d;
      end
   end

   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign cpu_hold     = cpu_hold_q;
   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StDone);
   assign error        = error_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: directed byte sessions, a stream-level write model and a
// per-cycle compare process that also keeps a copy of the instruction memory.
module tb_inst_mem_loader;

   logic        clk_CPU = 1'b0;
   logic        rst;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;
   logic [8:0]  words_loaded;

   inst_mem_loader #(.ADDR_WIDTH(8)) dut (
      .clk_CPU      (clk_CPU),
      .rst          (rst),
      .start        (start),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .cpu_hold     (cpu_hold),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk_CPU = ~clk_CPU;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          last_we = -1;
   int          last_done = -1;
   int          done_cnt = 0;
   logic [7:0]  last_addr;
   logic [31:0] tb_mem [256];
   logic [7:0]  bq [$];
   wr_t         exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk_CPU) cyc <= cyc + 1;

   // Per-cycle compare: writes against the expected stream, cpu_hold tracks session activity.
   always @(negedge clk_CPU) begin
      if (!rst) begin
         chk("hold_vs_busy", 32'(cpu_hold), 32'(busy));
         if (mem_we) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", 32'(mem_addr), 32'(e.addr));
               chk("wr_data", mem_wdata, e.data);
            end
            tb_mem[mem_addr] = mem_wdata;
            last_we   = cyc;
            last_addr = mem_addr;
         end
         if (done) begin
            done_cnt++;
            last_done = cyc;
         end
      end
   end

   // Model: the words a well-formed stream in bq must produce, in order.
   function automatic void model_writes(input int max_words);
      int cnt;
      cnt = {bq[0], bq[1]};
      if (cnt == 0 || cnt > 256) return;
      for (int w = 0; w < cnt && w < max_words; w++) begin
         wr_t e;
         e.addr = 8'(w);
         e.data = {bq[2+4*w], bq[3+4*w], bq[4+4*w], bq[5+4*w]};
         exp_q.push_back(e);
      end
   endfunction

   task automatic do_start();
      @(posedge clk_CPU); #1 start = 1'b1;
      @(posedge clk_CPU); #1 start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_err_clr", 32'(error), 32'd0);
      chk("start_wl_clr", 32'(words_loaded), 32'd0);
   endtask

   task automatic send_bytes(input int gap_pct, input int start_at, input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         int t;
         if (gap_pct > 0) begin
            while ($urandom_range(99) < gap_pct) begin
               byte_valid = 1'b0;
               @(posedge clk_CPU); #1;
            end
         end
         byte_valid = 1'b1;
         byte_data  = bq[i];
         start      = (i == start_at);
         t = 0;
         forever begin
            @(negedge clk_CPU);
            if (byte_ready) break;
            t++;
            if (t > 50) begin
               chk("ready_timeout", 32'(i), 32'hFFFF_FFFF);
               byte_valid = 1'b0;
               start      = 1'b0;
               return;
            end
         end
         acc_cyc = cyc;
         @(posedge clk_CPU); #1;
         start = 1'b0;
      end
      byte_valid = 1'b0;
   endtask

   task automatic run_session(input string name, input int gap_pct, input int start_at,
                              input int exp_wl, input logic exp_err, input int exp_done);
      int d0;
      int t;
      d0 = done_cnt;
      do_start();
      send_bytes(gap_pct, start_at, bq.size());
      t = 0;
      while (busy && t < 20) begin
         @(negedge clk_CPU);
         t++;
      end
      chk({name, "_idle"}, 32'(busy), 32'd0);
      chk({name, "_wl"}, 32'(words_loaded), 32'(exp_wl));
      chk({name, "_err"}, 32'(error), 32'(exp_err));
      chk({name, "_hold"}, 32'(cpu_hold), 32'd0);
      chk({name, "_done_cnt"}, 32'(done_cnt - d0), 32'(exp_done));
      chk({name, "_wr_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      byte_valid = 1'b0;
      byte_data = 8'h00;
      for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
      #12;
      chk("rst_ready", 32'(byte_ready), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(error), 32'd0);
      chk("rst_wl", 32'(words_loaded), 32'd0);
      rst = 1'b0;

      // 1: two words back-to-back
      bq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
      model_writes(256);
      run_session("t1", 0, -1, 2, 1'b0, 1);
      chk("t1_mem0", tb_mem[0], 32'h2008_0005);
      chk("t1_mem1", tb_mem[1], 32'hAC01_0004);
      chk("t1_done_after_we", 32'(last_done - last_we), 32'd1);

      // 2: empty load
      bq = '{8'h00, 8'h00};
      run_session("t2", 0, -1, 0, 1'b0, 1);
      chk("t2_done_timing", 32'(last_done - acc_cyc), 32'd1);

      // 3: oversize header
      bq = '{8'h01, 8'h01};
      run_session("t3", 0, -1, 0, 1'b1, 0);

      // 4: three words with ~50% valid gaps; start also clears the sticky error
      bq = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
             8'h99, 8'hAA, 8'hBB, 8'hCC};
      model_writes(256);
      run_session("t4", 50, -1, 3, 1'b0, 1);
      chk("t4_mem0", tb_mem[0], 32'h1122_3344);
      chk("t4_mem2", tb_mem[2], 32'h99AA_BBCC);

      // 5: reset after six data bytes
      bq = '{8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04,
             8'h05, 8'h06, 8'h07, 8'h08};
      model_writes(1);
      do_start();
      send_bytes(0, -1, 8);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_ready", 32'(byte_ready), 32'd0);
      chk("t5_rst_we", 32'(mem_we), 32'd0);
      chk("t5_rst_addr", 32'(mem_addr), 32'd0);
      chk("t5_rst_wdata", mem_wdata, 32'd0);
      chk("t5_rst_hold", 32'(cpu_hold), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_wl", 32'(words_loaded), 32'd0);
      @(posedge clk_CPU); #1 rst = 1'b0;
      chk("t5_wr_left", 32'(exp_q.size()), 32'd0);
      chk("t5_mem0", tb_mem[0], 32'hDEAD_BEEF);
      chk("t5_mem1_untouched", tb_mem[1], 32'h5566_7788);

      // 6: full-depth load with start pulsed mid-stream
      bq = '{8'h01, 8'h00};
      for (int w = 0; w < 256; w++) begin
         bq.push_back(8'hC0);
         bq.push_back(8'(w));
         bq.push_back(8'h5A);
         bq.push_back(~8'(w));
      end
      model_writes(256);
      run_session("t6", 0, 100, 256, 1'b0, 1);
      chk("t6_last_addr", 32'(last_addr), 32'hFF);
      chk("t6_mem255", tb_mem[255], 32'hC0FF_5A00);
      chk("t6_mem0", tb_mem[0], 32'hC000_5AFF);

      repeat (3) @(posedge clk_CPU);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
